// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Shared definitions for the UART transmit and receive blocks.
//  - uart_state_t : 2-bit frame FSM encoding (IDLE/START/DATA/STOP), used by
//                   both uart_rx and uart_tx so debug views decode the same way.
//  - DBIT_DEF / OS_DEF / SB_TICK_DEF : default frame geometry (8N1, 16x).
//  - max_int / cnt_width : helpers for sizing the tick and bit counters.
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int DBIT_DEF    = 8;
   localparam int OS_DEF      = 16;
   localparam int SB_TICK_DEF = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Width needed to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
//  Two-flop synchronizer for the asynchronous serial line. Both flops reset
//  to 1 (line idle level) so that leaving reset never looks like a start bit.
//  Ports:
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset
//   d    in  asynchronous input
//   q    out synchronized output (two clk of latency)
// ---------------------------------------------------------------------------
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//  Serial-to-parallel UART receiver, 8N1 by default, LSB first, paced by a
//  16x oversampling tick shared with the baud generator. Samples every bit at
//  its centre, holds one received word for the host and reports framing and
//  overrun errors.
//  Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   rx           in   serial input, idle high, asynchronous to clk
//   s_tick       in   one-clk pulse, OS pulses per bit time
//   rx_rd        in   host consumed rx_dout (pulse)
//   rx_dout      out  received word (holding register)
//   rx_valid     out  holding register holds an unread word
//   rx_done_tick out  one-clk pulse at the end of every frame, good or bad
//   frame_err    out  stop bit of the word in rx_dout was sampled low
//   overrun_err  out  sticky: a frame was dropped because rx_valid was set
//  DBIT must be at least 2 (the shift register shifts in from the MSB).
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF,
   parameter int OS      = OS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            rx_rd,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_valid,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            overrun_err
);

   localparam int SW = cnt_width(max_int(OS, SB_TICK));
   localparam int NW = cnt_width(DBIT);

   // Tick counts at which the FSM acts. The start bit is checked half a bit
   // after the falling edge; from there every OS ticks lands on a bit centre.
   localparam logic [SW-1:0] S_MID      = SW'(OS / 2 - 1);
   localparam logic [SW-1:0] S_BIT_END  = SW'(OS - 1);
   localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

   // Synchronized serial line; the raw rx is never used past this point.
   logic rx_s;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (reset),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM and datapath state.
   uart_state_t     state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;

   // Host-facing holding register and flags.
   logic [DBIT-1:0] dout_q, dout_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic            fe_q, fe_d;
   logic            ovr_q, ovr_d;

   // High for the single cycle in which the stop bit is sampled.
   logic            frame_end;

   // ------------------------------------------------------------------
   // Next-state logic for the frame FSM. All counting is gated by s_tick
   // so nothing moves between ticks except the IDLE start detection.
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      n_d       = n_q;
      b_d       = b_q;
      frame_end = 1'b0;

      unique case (state_q)
         IDLE: begin
            s_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end

         START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  // A line that is high again at mid start bit was a glitch.
                  if (rx_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT_END) begin
                  // LSB arrives first, so shift in at the top.
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  s_d = '0;
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP_END) begin
                  // Back to IDLE even on a low stop bit; a held-low line
                  // (break) simply restarts start-bit qualification.
                  frame_end = 1'b1;
                  state_d   = IDLE;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Holding register. A frame commits in the cycle its stop bit is
   // sampled; a read in that same cycle frees the register for the new
   // word, so the new word is never dropped when the host is keeping up.
   // ------------------------------------------------------------------
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      fe_d    = fe_q;
      ovr_d   = ovr_q;
      done_d  = frame_end;

      if (frame_end) begin
         if (!valid_q || rx_rd) begin
            dout_d  = b_q;
            fe_d    = ~rx_s;
            valid_d = 1'b1;
            if (rx_rd) begin
               ovr_d = 1'b0;
            end
         end else begin
            // Unread word still present: keep it and flag the loss.
            ovr_d = 1'b1;
         end
      end else if (rx_rd && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_dout      = dout_q;
   assign rx_valid     = valid_q;
   assign rx_done_tick = done_q;
   assign frame_err    = fe_q;
   assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//  Directed bench for uart_rx: s_tick every 4 clk, 64 clk per bit. Each frame
//  pushes its expected {overrun_err, frame_err, rx_dout} into exp_q; a monitor
//  pops on every rx_done_tick and compares. Direct checks cover reset, reads,
//  the start glitch and reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CLK_PER_BIT = 64;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       s_tick;
   logic       rx_rd;
   logic [7:0] rx_dout;
   logic       rx_valid;
   logic       rx_done_tick;
   logic       frame_err;
   logic       overrun_err;

   logic [9:0] exp_q[$];
   int         n_checks;
   int         n_fail;
   int         done_cnt;

   uart_rx dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .rx_rd        (rx_rd),
      .rx_dout      (rx_dout),
      .rx_valid     (rx_valid),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .overrun_err  (overrun_err)
   );

   // ---------------- clock / reset / tick ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every completed frame must match the head of the queue.
   always @(negedge clk) begin
      if (!reset && rx_done_tick) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(rx_dout), 32'hFFFF_FFFF);
         end else begin
            check("frame", {21'd0, rx_valid, overrun_err, frame_err, rx_dout},
                  {21'd0, 1'b1, exp_q.pop_front()});
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] d, input bit stop_ok);
      @(negedge clk);
      rx = 1'b0;
      repeat (CLK_PER_BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CLK_PER_BIT) @(negedge clk);
      end
      if (stop_ok) begin
         rx = 1'b1;
         repeat (CLK_PER_BIT) @(negedge clk);
      end else begin
         // Low long enough to cover the stop sample, then released well
         // before the re-entered START would qualify it as a start bit.
         rx = 1'b0;
         repeat (40) @(negedge clk);
         rx = 1'b1;
         repeat (CLK_PER_BIT - 40) @(negedge clk);
      end
      repeat (CLK_PER_BIT) @(negedge clk);
   endtask

   task automatic read_word(input logic [7:0] held);
      @(negedge clk);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      check("read_valid", 32'(rx_valid), 32'd0);
      check("read_ovr", 32'(overrun_err), 32'd0);
      check("read_dout_held", 32'(rx_dout), 32'(held));
   endtask

   // Raises rx_rd for exactly the cycle in which the stop bit commits.
   task automatic rd_at_commit();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(posedge clk);
         #1;
         if (dut.state_q == STOP && s_tick && dut.s_q == 4'd15) begin
            rx_rd = 1'b1;
            @(posedge clk);
            #1;
            rx_rd = 1'b0;
            found = 1'b1;
         end
      end
      check("rd_at_commit_found", 32'(found), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] loop_bytes[4];
      int         done_before;
      loop_bytes[0] = 8'h00;
      loop_bytes[1] = 8'hFF;
      loop_bytes[2] = 8'h55;
      loop_bytes[3] = 8'h3C;
      n_checks = 0;
      n_fail   = 0;
      done_cnt = 0;
      reset    = 1'b1;
      rx       = 1'b1;
      rx_rd    = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_outputs", {18'd0, rx_done_tick, rx_valid, frame_err, overrun_err, rx_dout},
            32'd0);
      check("reset_state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Basic frame
      exp_q.push_back({1'b0, 1'b0, 8'hA5});
      send_byte(8'hA5, 1'b1);
      check("a5_done_count", 32'(done_cnt), 32'd1);
      read_word(8'hA5);

      // Byte patterns as a transmitter would send them
      foreach (loop_bytes[i]) begin
         exp_q.push_back({1'b0, 1'b0, loop_bytes[i]});
         send_byte(loop_bytes[i], 1'b1);
         read_word(loop_bytes[i]);
      end

      // Framing error, then recovery
      exp_q.push_back({1'b0, 1'b1, 8'h81});
      send_byte(8'h81, 1'b0);
      read_word(8'h81);
      check("fe_idle_after", 32'(dut.state_q), 32'(IDLE));
      exp_q.push_back({1'b0, 1'b0, 8'h42});
      send_byte(8'h42, 1'b1);
      read_word(8'h42);

      // Start glitch: 5 ticks low
      done_before = done_cnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (150) @(negedge clk);
      check("glitch_no_done", 32'(done_cnt), 32'(done_before));
      check("glitch_state", 32'(dut.state_q), 32'(IDLE));
      check("glitch_outputs", {21'd0, rx_valid, overrun_err, frame_err, rx_dout},
            {21'd0, 1'b0, 1'b0, 1'b0, 8'h42});

      // Overrun
      exp_q.push_back({1'b0, 1'b0, 8'h11});
      send_byte(8'h11, 1'b1);
      exp_q.push_back({1'b1, 1'b0, 8'h11});
      send_byte(8'h22, 1'b1);
      check("ovr_dout", 32'(rx_dout), 32'h11);
      check("ovr_flag", 32'(overrun_err), 32'd1);
      read_word(8'h11);

      // Read in the commit cycle: new word loads, rx_valid stays set
      exp_q.push_back({1'b0, 1'b0, 8'h33});
      send_byte(8'h33, 1'b1);
      exp_q.push_back({1'b0, 1'b0, 8'h44});
      fork
         send_byte(8'h44, 1'b1);
         rd_at_commit();
      join
      check("rd_commit_valid", 32'(rx_valid), 32'd1);
      check("rd_commit_dout", 32'(rx_dout), 32'h44);
      check("rd_commit_ovr", 32'(overrun_err), 32'd0);

      // Reset in the middle of bit 3 of 0x5A
      @(negedge clk);
      rx = 1'b0;
      repeat (CLK_PER_BIT) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = (i == 1) ? 1'b1 : 1'b0;
         repeat (CLK_PER_BIT) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CLK_PER_BIT / 2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_outputs", {18'd0, rx_done_tick, rx_valid, frame_err, overrun_err, rx_dout},
            32'd0);
      check("midreset_state", 32'(dut.state_q), 32'(IDLE));
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      exp_q.push_back({1'b0, 1'b0, 8'h96});
      send_byte(8'h96, 1'b1);
      check("post_reset_dout", 32'(rx_dout), 32'h96);

      repeat (50) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("total_frames", 32'(done_cnt), 32'd12);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
